tree_adder_pipe: RTL and testbench
==================================

Name: tree_adder_pipe

Overview:
Parametrised pipelined signed fixed-point tree adder. It reduces N_IN lanes to one sum through log2(N_IN) registered pairwise levels, then a final accumulate/saturate stage. It is the next generation of the 8-input tree adder used in the wafer-fault detection datapath. New capabilities over the previous generation:
- generic lane count;
- valid/last framing;
- optional multi-beat accumulation for dot products longer than N_IN;
- saturating output with an overflow flag.

Parameters:
- WIDTH, 16: lane and output width, signed two's complement (Q8.8 at default; the binary point does not affect the arithmetic).
- N_IN, 8: number of input lanes. Must be a power of two, 2..64. Elaboration error otherwise.
- ACC_W, 32: accumulator width. Must be >= WIDTH+log2(N_IN).

Ports:
- clk  in  1  clock, all registers on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  pipeline advance. When 0, all state holds.
- clr  in  1  synchronous flush of the pipeline and accumulator.
- in_valid  in  1  input beat valid.
- in_last  in  1  last beat of an accumulation frame (acc mode only).
- acc_mode  in  1  0 = per-beat sum, 1 = accumulate across beats. Sampled with each beat.
- in_data  in  N_IN*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  1  out_data/out_sat are valid this cycle.
- out_data  out  WIDTH  saturated sum.
- out_sat  out  1  result was clipped at some point for this output.

Behaviour:
- Definitions: LEVELS = log2(N_IN). Latency LAT = LEVELS+1 enabled cycles from input beat to out_valid.
- Tree width growth: level k (k = 1..LEVELS) registers sums WIDTH+k bits wide, sign-extended. No truncation or rounding inside the tree.
- Sideband: valid, last and acc_mode travel in shift registers alongside the data, LEVELS deep.
- Final stage, per-beat mode (acc_mode=0): out_data = sat_WIDTH(tree sum); out_valid=1; the accumulator is untouched.
- Final stage, acc mode (acc_mode=1):
  - Loading: acc <= tree sum if acc_empty, else acc + tree sum.
  - Saturation: the add saturates at ACC_W bounds, and any clip sets the sticky acc_sat.
  - Emission: on a beat with last=1, emit out_data = sat_WIDTH(acc+sum), out_sat = acc_sat OR clip, out_valid=1. Then acc_empty=1 and acc_sat=0.
  - Non-last beats: out_valid=0.
- Saturation rule: value > 2^(WIDTH-1)-1 clips to 0x7FFF (at WIDTH=16); value < -2^(WIDTH-1) clips to 0x8000. out_sat=1 when clipped.
- Output timing: out_valid is a single-cycle pulse per result, held only while en=0. out_data holds its last value when out_valid=0.
- en=0: every register holds, including the valid pipe and the accumulator. An out_valid that was high stays high.
- clr=1 (priority over en): next edge clears the valid pipe, out_valid, acc, acc_sat, and sets acc_empty=1. Data registers may keep stale values.
- rst (asynchronous): all registers to 0, acc_empty=1. Outputs out_valid=0, out_data=0, out_sat=0. Reset mid-frame discards the partial accumulation.
- Mode switching: mixing acc_mode=0 beats inside an open acc frame is legal. Those beats pass through and do not disturb acc.
- in_last with acc_mode=0 is ignored.
- Invalid beats (in_valid=0) never touch acc.

Decomposition:
- Package tree_adder_pkg:
  - clog2 function;
  - signed saturate function (value, from_w, to_w) that returns the clip flag;
  - localparam helpers for LEVELS and the level width.
- One sub-module, tree_adder_level:
  - parameters IN_W and N;
  - N signed inputs -> N/2 registered sums of IN_W+1 bits;
  - en hold; no reset on data, reset on nothing else.
- The top generates LEVELS instances plus the sideband shift register and the final accumulate/saturate stage.

Test Plan:
- Per-beat sum: N_IN=8, en=1, one valid beat with lanes 0x0100..0x0800 (1.0..8.0) -> after 4 cycles out_valid pulses with out_data=0x2400, out_sat=0.
- Negative lanes: 0xFF00..0xF800 -> out_data=0xDC00 (-36.0). Back-to-back with the previous case -> two consecutive out_valid pulses.
- Saturation:
  - all lanes 0x7000 -> out_data=0x7FFF, out_sat=1;
  - all lanes 0x8000 -> out_data=0x8000, out_sat=1.
- Accumulate: acc_mode=1, three beats all lanes 0x0100, in_last on the third -> exactly one out_valid, 4 cycles after the third beat, out_data=0x1800. A following frame of one beat all 0x0100 -> 0x0800 (accumulator restarted).
- Stall and flush:
  - en=0 for 3 cycles mid-flight -> output delayed exactly 3 cycles, value unchanged.
  - clr with two beats in flight -> no out_valid, and the next acc frame starts from 0.
- Async reset: assert rst between clock edges during an acc frame -> outputs 0 immediately. After release, a fresh frame yields the correct sum with no carry-over. Repeat with N_IN=2 and N_IN=32.

Source files
------------

// File: rtl/tree_adder_pkg.sv
// Shared helpers for the pipelined signed tree adder: sizing and saturation.
package tree_adder_pkg;

    // Internal width large enough to hold any accumulator sum before clipping.
    localparam int unsigned MaxW = 128;
    typedef logic signed [MaxW-1:0] wide_t;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

    // Width of the sums registered by tree level k.
    function automatic int unsigned level_w(input int unsigned width, input int unsigned k);
        return width + k;
    endfunction

    localparam int unsigned DefNIn   = 8;
    localparam int unsigned DefLevels = clog2(DefNIn);

    // Clip a from_w-bit signed value into the to_w-bit signed range; clip reports it.
    function automatic wide_t saturate(input wide_t value, input int unsigned from_w,
                                       input int unsigned to_w, output logic clip);
        wide_t hi, lo, res;
        hi   = (wide_t'(1) <<< (to_w - 1)) - wide_t'(1);
        lo   = -hi - wide_t'(1);
        clip = 1'b0;
        res  = value;
        if (to_w < from_w) begin
            if (value > hi) begin
                res  = hi;
                clip = 1'b1;
            end else if (value < lo) begin
                res  = lo;
                clip = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tree_adder_pipe_if.sv
// Beat/result bus of the tree adder; the producer drives beats, the adder drives results.
interface tree_adder_pipe_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N_IN  = 8
);
    logic                   en;
    logic                   clr;
    logic                   in_valid;
    logic                   in_last;
    logic                   acc_mode;
    logic [N_IN*WIDTH-1:0]  in_data;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic                   out_sat;

    modport master (
        output en, clr, in_valid, in_last, acc_mode, in_data,
        input  out_valid, out_data, out_sat
    );

    modport slave (
        input  en, clr, in_valid, in_last, acc_mode, in_data,
        output out_valid, out_data, out_sat
    );
endinterface

// File: rtl/tree_adder_level.sv
// One registered level of the adder tree: N lanes in, N/2 pairwise sums one bit wider.
module tree_adder_level
    import tree_adder_pkg::*;
#(
    parameter int unsigned IN_W = 16,
    parameter int unsigned N    = 8
) (
    input  logic                              clk,
    input  logic                              en,
    input  logic [N*IN_W-1:0]                 in_data,
    output logic [(N/2)*level_w(IN_W, 1)-1:0] out_data
);
    localparam int unsigned OUT_W = level_w(IN_W, 1);

    logic [(N/2)*OUT_W-1:0] sum_d, sum_q;

    // Pairwise sign-extended sums; one extra bit so no pair can overflow.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N / 2; i++) begin
            sum_d[i*OUT_W +: OUT_W] =
                {in_data[(2*i+1)*IN_W-1], in_data[2*i*IN_W +: IN_W]} +
                {in_data[(2*i+2)*IN_W-1], in_data[(2*i+1)*IN_W +: IN_W]};
        end
    end

    // Data-only register: stale contents are harmless because validity travels separately.
    always_ff @(posedge clk) begin
        if (en) sum_q <= sum_d;
    end

    assign out_data = sum_q;
endmodule

// File: rtl/tree_adder_pipe.sv
// Pipelined signed tree adder with per-beat or multi-beat accumulation and saturation.
module tree_adder_pipe
    import tree_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N_IN  = 8,
    parameter int unsigned ACC_W = 32
) (
    input logic              clk,
    input logic              rst,
    tree_adder_pipe_if.slave bus
);
    localparam int unsigned LEVELS = clog2(N_IN);
    localparam int unsigned SUM_W  = level_w(WIDTH, LEVELS);

    if (N_IN < 2 || N_IN > 64 || (N_IN & (N_IN - 1)) != 0) begin : g_bad_n_in
        $error("tree_adder_pipe: N_IN must be a power of two in 2..64");
    end
    if (ACC_W < SUM_W || ACC_W + 1 > MaxW) begin : g_bad_acc_w
        $error("tree_adder_pipe: ACC_W too narrow for the tree sum or too wide");
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int unsigned InW = level_w(WIDTH, k - 1);
        localparam int unsigned Nl  = N_IN >> (k - 1);
        logic [Nl*InW-1:0]         lvl_in;
        logic [(Nl/2)*(InW+1)-1:0] lvl_out;
        if (k == 1) begin : g_first
            assign lvl_in = bus.in_data;
        end else begin : g_next
            assign lvl_in = g_lvl[k-1].lvl_out;
        end
        tree_adder_level #(
            .IN_W (InW),
            .N    (Nl)
        ) u_level (
            .clk      (clk),
            .en       (bus.en),
            .in_data  (lvl_in),
            .out_data (lvl_out)
        );
    end

    logic signed [SUM_W-1:0] tree_sum;
    assign tree_sum = g_lvl[LEVELS].lvl_out;

    logic [LEVELS-1:0] vld_q, last_q, mode_q;

    // Sideband shift registers keep each beat's framing aligned with its partial sums.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            last_q <= '0;
            mode_q <= '0;
        end else if (bus.clr) begin
            vld_q <= '0;
        end else if (bus.en) begin
            vld_q  <= LEVELS'({vld_q, bus.in_valid});
            last_q <= LEVELS'({last_q, bus.in_last});
            mode_q <= LEVELS'({mode_q, bus.acc_mode});
        end
    end

    logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic                    acc_empty_q, acc_empty_d, acc_sat_q, acc_sat_d;
    logic                    out_valid_q, out_valid_d, out_sat_q, out_sat_d;
    logic [WIDTH-1:0]        out_data_q, out_data_d;
    logic signed [WIDTH-1:0] beat_val, emit_val;
    logic                    clip_beat, clip_acc, clip_emit;
    wide_t                   sum_w, base_w;

    // Candidate results: direct per-beat clip, ACC_W-clipped running sum, and its output clip.
    always_comb begin
        sum_w    = wide_t'(tree_sum);
        base_w   = acc_empty_q ? '0 : wide_t'(acc_q);
        beat_val = WIDTH'(saturate(sum_w, SUM_W, WIDTH, clip_beat));
        acc_sum  = ACC_W'(saturate(base_w + sum_w, ACC_W + 1, ACC_W, clip_acc));
        emit_val = WIDTH'(saturate(wide_t'(acc_sum), ACC_W, WIDTH, clip_emit));
    end

    // Final stage next-state: per-beat pass-through, accumulate, or emit on frame end.
    always_comb begin
        acc_d       = acc_q;
        acc_empty_d = acc_empty_q;
        acc_sat_d   = acc_sat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (bus.en) begin
            out_valid_d = 1'b0;
            if (vld_q[LEVELS-1]) begin
                if (!mode_q[LEVELS-1]) begin
                    out_valid_d = 1'b1;
                    out_data_d  = beat_val;
                    out_sat_d   = clip_beat;
                end else if (last_q[LEVELS-1]) begin
                    out_valid_d = 1'b1;
                    out_data_d  = emit_val;
                    out_sat_d   = acc_sat_q | clip_acc | clip_emit;
                    acc_d       = '0;
                    acc_empty_d = 1'b1;
                    acc_sat_d   = 1'b0;
                end else begin
                    acc_d       = acc_sum;
                    acc_empty_d = 1'b0;
                    acc_sat_d   = acc_sat_q | clip_acc;
                end
            end
        end
    end

    // Accumulator and output registers; clr flushes the frame but leaves out_data/out_sat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            acc_empty_q <= 1'b1;
            acc_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (bus.clr) begin
            acc_q       <= '0;
            acc_empty_q <= 1'b1;
            acc_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_empty_q <= acc_empty_d;
            acc_sat_q   <= acc_sat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_tree_adder_pipe.sv
// Bench for tree_adder_pipe: three instances (8, 2 and 32 lanes) share one stimulus stream.
module tb_tree_adder_pipe;
    localparam int ACC_W = 32;

    logic clk, rst, en, clr, in_valid, in_last, acc_mode;
    logic [15:0] lanes [32];

    int total = 0;
    int bad   = 0;

    tree_adder_pipe_if #(.WIDTH(16), .N_IN(8))  bus8 ();
    tree_adder_pipe_if #(.WIDTH(16), .N_IN(2))  bus2 ();
    tree_adder_pipe_if #(.WIDTH(16), .N_IN(32)) bus32 ();

    tree_adder_pipe #(.WIDTH(16), .N_IN(8),  .ACC_W(ACC_W)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    tree_adder_pipe #(.WIDTH(16), .N_IN(2),  .ACC_W(ACC_W)) dut2  (.clk(clk), .rst(rst), .bus(bus2.slave));
    tree_adder_pipe #(.WIDTH(16), .N_IN(32), .ACC_W(ACC_W)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

    assign bus8.en = en;        assign bus2.en = en;        assign bus32.en = en;
    assign bus8.clr = clr;      assign bus2.clr = clr;      assign bus32.clr = clr;
    assign bus8.in_valid = in_valid; assign bus2.in_valid = in_valid; assign bus32.in_valid = in_valid;
    assign bus8.in_last = in_last;   assign bus2.in_last = in_last;   assign bus32.in_last = in_last;
    assign bus8.acc_mode = acc_mode; assign bus2.acc_mode = acc_mode; assign bus32.acc_mode = acc_mode;

    always_comb begin
        for (int i = 0; i < 8; i++) bus8.in_data[i*16 +: 16] = lanes[i];
        for (int i = 0; i < 2; i++) bus2.in_data[i*16 +: 16] = lanes[i];
        for (int i = 0; i < 32; i++) bus32.in_data[i*16 +: 16] = lanes[i];
    end

    logic ov [3];
    logic [15:0] od [3];
    logic os [3];
    assign ov[0] = bus8.out_valid;  assign od[0] = bus8.out_data;  assign os[0] = bus8.out_sat;
    assign ov[1] = bus2.out_valid;  assign od[1] = bus2.out_data;  assign os[1] = bus2.out_sat;
    assign ov[2] = bus32.out_valid; assign od[2] = bus32.out_data; assign os[2] = bus32.out_sat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int n_of(input int d);
        return (d == 0) ? 8 : (d == 1) ? 2 : 32;
    endfunction

    function automatic int lv_of(input int d);
        return (d == 0) ? 3 : (d == 1) ? 1 : 5;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint sat_to(input longint v, input int w, output bit clip);
        longint hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        clip = 1'b0;
        if (v > hi) begin clip = 1'b1; return hi; end
        if (v < lo) begin clip = 1'b1; return lo; end
        return v;
    endfunction

    function automatic longint lane_sum(input int n);
        longint s;
        s = 0;
        for (int i = 0; i < n; i++) s += longint'($signed(lanes[i]));
        return s;
    endfunction

    typedef struct {
        longint sum;
        bit     last;
        bit     mode;
        longint born;
    } beat_t;

    beat_t       inflight [3][$];
    longint      ecount = 0;
    longint      m_acc [3]   = '{0, 0, 0};
    bit          m_empty [3] = '{1, 1, 1};
    bit          m_accsat [3] = '{0, 0, 0};
    bit          e_valid [3] = '{0, 0, 0};
    logic [15:0] e_data [3]  = '{16'h0, 16'h0, 16'h0};
    bit          e_sat [3]   = '{0, 0, 0};

    // A beat accepted on enabled edge e produces its effect on enabled edge e + log2(N).
    initial begin : model
        beat_t  b;
        longint t;
        bit     c1, c2;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                ecount = 0;
                for (int d = 0; d < 3; d++) begin
                    inflight[d].delete();
                    m_acc[d] = 0; m_empty[d] = 1'b1; m_accsat[d] = 1'b0;
                    e_valid[d] = 1'b0; e_data[d] = 16'h0; e_sat[d] = 1'b0;
                end
            end else if (clr) begin
                for (int d = 0; d < 3; d++) begin
                    inflight[d].delete();
                    m_acc[d] = 0; m_empty[d] = 1'b1; m_accsat[d] = 1'b0;
                    e_valid[d] = 1'b0;
                end
            end else if (en) begin
                ecount++;
                for (int d = 0; d < 3; d++) begin
                    e_valid[d] = 1'b0;
                    if (inflight[d].size() > 0 && inflight[d][0].born + lv_of(d) == ecount) begin
                        b = inflight[d].pop_front();
                        if (!b.mode) begin
                            e_valid[d] = 1'b1;
                            e_data[d]  = 16'(sat_to(b.sum, 16, c1));
                            e_sat[d]   = c1;
                        end else begin
                            t = sat_to((m_empty[d] ? 0 : m_acc[d]) + b.sum, ACC_W, c1);
                            if (b.last) begin
                                e_valid[d] = 1'b1;
                                e_data[d]  = 16'(sat_to(t, 16, c2));
                                e_sat[d]   = m_accsat[d] | c1 | c2;
                                m_acc[d] = 0; m_empty[d] = 1'b1; m_accsat[d] = 1'b0;
                            end else begin
                                m_acc[d] = t; m_empty[d] = 1'b0;
                                m_accsat[d] = m_accsat[d] | c1;
                            end
                        end
                    end
                    if (in_valid)
                        inflight[d].push_back('{sum: lane_sum(n_of(d)), last: in_last,
                                                mode: acc_mode, born: ecount});
                end
            end
        end
    end

    // Every cycle, all three instances against the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                check($sformatf("dut%0d out_valid", d), 32'(ov[d]), 32'(e_valid[d]));
                check($sformatf("dut%0d out_data", d), 32'(od[d]), 32'(e_data[d]));
                check($sformatf("dut%0d out_sat", d), 32'(os[d]), 32'(e_sat[d]));
            end
        end
    end

    // ---------------- stimulus ----------------
    int np [3], plat [3], plast [3];
    logic [15:0] pdata [3], plast_data [3];
    logic psat [3];

    task automatic fill_ramp(input int step);
        for (int i = 0; i < 32; i++) lanes[i] = 16'((i + 1) * step);
    endtask

    task automatic fill_const(input logic [15:0] v);
        for (int i = 0; i < 32; i++) lanes[i] = v;
    endtask

    // Present one valid beat for exactly one rising edge.
    task automatic beat(input bit last, input bit mode);
        in_valid = 1'b1; in_last = last; acc_mode = mode;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Watch outputs; c counts edges since the last beat's sampling edge (that edge is 1).
    task automatic observe(input int first_c, input int last_c);
        for (int d = 0; d < 3; d++) begin
            np[d] = 0; plat[d] = 0; plast[d] = 0; pdata[d] = 16'h0;
            plast_data[d] = 16'h0; psat[d] = 1'b0;
        end
        for (int c = first_c; c <= last_c; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (ov[d] === 1'b1) begin
                    np[d]++;
                    if (np[d] == 1) begin plat[d] = c; pdata[d] = od[d]; psat[d] = os[d]; end
                    plast[d] = c; plast_data[d] = od[d];
                end
            end
        end
    endtask

    initial begin : stim
        rst = 1'b1; en = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; acc_mode = 1'b0;
        fill_const(16'h0);
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset out_valid dut%0d", d), 32'(ov[d]), 32'h0);
            check($sformatf("reset out_data dut%0d", d), 32'(od[d]), 32'h0);
            check($sformatf("reset out_sat dut%0d", d), 32'(os[d]), 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        // 1.0 .. 8.0
        fill_ramp(256); beat(1'b0, 1'b0); observe(2, 10);
        check("ramp pulses", 32'(np[0]), 32'd1);
        check("ramp latency", 32'(plat[0]), 32'd4);
        check("ramp data", 32'(pdata[0]), 32'h2400);
        check("ramp sat", 32'(psat[0]), 32'h0);
        check("ramp n2 data", 32'(pdata[1]), 32'h0300);

        // Back-to-back positive then negative ramp.
        fill_ramp(256); beat(1'b0, 1'b0);
        fill_ramp(-256); beat(1'b0, 1'b0); observe(2, 10);
        check("b2b pulses", 32'(np[0]), 32'd2);
        check("b2b first at", 32'(plat[0]), 32'd3);
        check("b2b second at", 32'(plast[0]), 32'd4);
        check("b2b first data", 32'(pdata[0]), 32'h2400);
        check("b2b neg data", 32'(plast_data[0]), 32'hDC00);

        // Saturation both ways.
        fill_const(16'h7000); beat(1'b0, 1'b0);
        fill_const(16'h8000); beat(1'b0, 1'b0); observe(2, 10);
        check("sat pos data", 32'(pdata[0]), 32'h7FFF);
        check("sat pos flag", 32'(psat[0]), 32'h1);
        check("sat neg data", 32'(plast_data[0]), 32'h8000);

        // Three-beat frame, then a one-beat frame.
        fill_const(16'h0100);
        beat(1'b0, 1'b1); beat(1'b0, 1'b1); beat(1'b1, 1'b1); acc_mode = 1'b0; observe(2, 10);
        check("acc pulses", 32'(np[0]), 32'd1);
        check("acc latency", 32'(plat[0]), 32'd4);
        check("acc data", 32'(pdata[0]), 32'h1800);
        check("acc sat", 32'(psat[0]), 32'h0);
        beat(1'b1, 1'b1); acc_mode = 1'b0; observe(2, 10);
        check("acc restart data", 32'(pdata[0]), 32'h0800);

        // Stall three cycles mid-flight.
        fill_ramp(256); beat(1'b0, 1'b0);
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("stall holds out_valid n2", 32'(ov[1]), 32'h1);
        en = 1'b1; observe(6, 14);
        check("stall pulses", 32'(np[0]), 32'd1);
        check("stall latency", 32'(plat[0]), 32'd7);
        check("stall data", 32'(pdata[0]), 32'h2400);

        // Flush two acc beats in flight.
        fill_const(16'h0100);
        beat(1'b0, 1'b1); beat(1'b0, 1'b1);
        clr = 1'b1; @(negedge clk); clr = 1'b0; observe(2, 10);
        check("clr no pulse n8", 32'(np[0]), 32'd0);
        check("clr no pulse n32", 32'(np[2]), 32'd0);
        beat(1'b1, 1'b1); observe(2, 10);
        check("post clr data", 32'(pdata[0]), 32'h0800);
        check("post clr latency", 32'(plat[0]), 32'd4);

        // Async reset mid-frame.
        beat(1'b0, 1'b1); beat(1'b0, 1'b1);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("async rst out_valid dut%0d", d), 32'(ov[d]), 32'h0);
            check($sformatf("async rst out_data dut%0d", d), 32'(od[d]), 32'h0);
            check($sformatf("async rst out_sat dut%0d", d), 32'(os[d]), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        beat(1'b1, 1'b1); acc_mode = 1'b0; observe(2, 10);
        check("post rst n8 data", 32'(pdata[0]), 32'h0800);
        check("post rst n8 latency", 32'(plat[0]), 32'd4);
        check("post rst n2 data", 32'(pdata[1]), 32'h0200);
        check("post rst n2 latency", 32'(plat[1]), 32'd2);
        check("post rst n32 data", 32'(pdata[2]), 32'h2000);
        check("post rst n32 latency", 32'(plat[2]), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
